// File: rtl/vdma_wr_arbiter_pkg.sv
// Shared types and constants for the two-port VDMA write arbiter.
// Holds the burst FSM state type, the OKAY response code and fixed AXI write attributes.
package vdma_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY    = 2'b00;

    // Full-width 32-byte beats, incrementing bursts, bufferable/modifiable.
    localparam logic [2:0] AWSIZE_32B   = 3'b101;
    localparam logic [1:0] AWBURST_INCR = 2'b01;
    localparam logic [3:0] AWCACHE_BUF  = 4'b0011;
    localparam logic [2:0] AWPROT_DATA  = 3'b000;
    localparam logic [3:0] AWQOS_NONE   = 4'b0000;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin picker: when both ports request, the one not served last wins.
// last_grant resets to 1 so port 0 is served first after reset.
module rr_grant2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       update_en,
    input  logic       update_grant,
    output logic       pick
);

    logic last_grant_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            last_grant_reg <= 1'b1;
        end else if (update_en) begin
            last_grant_reg <= update_grant;
        end
    end

    always_comb begin
        pick = 1'b0;
        if (&req) begin
            pick = ~last_grant_reg;
        end else if (req[1]) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/vdma_wr_arbiter.sv
// Merges two upstream AXI write streams onto one master port, one burst at a time.
// Generates wlast from awlen, checks upstream wlast and flags bad write responses.
module vdma_wr_arbiter
    import vdma_wr_arbiter_pkg::*;
#(
    parameter int ASIZE     = 29,
    parameter int LSIZE     = 9,
    parameter int IDSIZE    = 4,
    parameter int AXI_DSIZE = 256
) (
    input  logic                     axi_aclk,
    input  logic                     axi_rst,
    input  logic [2*IDSIZE-1:0]      s_axi_awid,
    input  logic [2*ASIZE-1:0]       s_axi_awaddr,
    input  logic [2*LSIZE-1:0]       s_axi_awlen,
    input  logic [1:0]               s_axi_awvalid,
    output logic [1:0]               s_axi_awready,
    input  logic [2*AXI_DSIZE-1:0]   s_axi_wdata,
    input  logic [1:0]               s_axi_wlast,
    input  logic [1:0]               s_axi_wvalid,
    output logic [1:0]               s_axi_wready,
    output logic [3:0]               s_axi_bresp,
    output logic [1:0]               s_axi_bvalid,
    input  logic [1:0]               s_axi_bready,
    output logic [IDSIZE-1:0]        m_axi_awid,
    output logic [ASIZE-1:0]         m_axi_awaddr,
    output logic [LSIZE-1:0]         m_axi_awlen,
    output logic [2:0]               m_axi_awsize,
    output logic [1:0]               m_axi_awburst,
    output logic [3:0]               m_axi_awcache,
    output logic [2:0]               m_axi_awprot,
    output logic [3:0]               m_axi_awqos,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [AXI_DSIZE-1:0]     m_axi_wdata,
    output logic [AXI_DSIZE/8-1:0]   m_axi_wstrb,
    output logic                     m_axi_wlast,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [IDSIZE-1:0]        m_axi_bid,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic                     err_wlast,
    output logic                     err_resp
);

    wr_state_e         state_reg, state_next;
    logic              grant_reg;
    logic [IDSIZE-1:0] awid_reg;
    logic [LSIZE-1:0]  awlen_reg;
    logic [LSIZE-1:0]  beat_cnt_reg;
    logic              err_wlast_reg;
    logic              err_resp_reg;
    logic              pick;

    logic [IDSIZE-1:0]    awid_arr   [2];
    logic [ASIZE-1:0]     awaddr_arr [2];
    logic [LSIZE-1:0]     awlen_arr  [2];
    logic [AXI_DSIZE-1:0] wdata_arr  [2];
    logic [1:0]           bresp_arr  [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign awid_arr[gi]           = s_axi_awid[gi*IDSIZE +: IDSIZE];
            assign awaddr_arr[gi]         = s_axi_awaddr[gi*ASIZE +: ASIZE];
            assign awlen_arr[gi]          = s_axi_awlen[gi*LSIZE +: LSIZE];
            assign wdata_arr[gi]          = s_axi_wdata[gi*AXI_DSIZE +: AXI_DSIZE];
            assign s_axi_bresp[gi*2 +: 2] = bresp_arr[gi];
        end
    endgenerate

    logic aw_hs, w_hs, b_hs, last_beat;

    assign last_beat = (beat_cnt_reg == awlen_reg);
    assign aw_hs = (state_reg == ST_AW) && s_axi_awvalid[grant_reg] && m_axi_awready;
    assign w_hs  = (state_reg == ST_W)  && s_axi_wvalid[grant_reg]  && m_axi_wready;
    assign b_hs  = (state_reg == ST_B)  && m_axi_bvalid && s_axi_bready[grant_reg];

    rr_grant2 u_rr (
        .clk          (axi_aclk),
        .srst         (axi_rst),
        .req          (s_axi_awvalid),
        .update_en    (b_hs),
        .update_grant (grant_reg),
        .pick         (pick)
    );

    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= 1'b0;
            awid_reg      <= '0;
            awlen_reg     <= '0;
            beat_cnt_reg  <= '0;
            err_wlast_reg <= 1'b0;
            err_resp_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            err_resp_reg <= 1'b0;
            if (state_reg == ST_IDLE && |s_axi_awvalid) begin
                grant_reg <= pick;
                awid_reg  <= awid_arr[pick];
                awlen_reg <= awlen_arr[pick];
            end
            if (w_hs) begin
                beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
                // Upstream wlast is only checked; beat count always comes from awlen.
                if (s_axi_wlast[grant_reg] != last_beat) begin
                    err_wlast_reg <= 1'b1;
                end
            end
            if (b_hs) begin
                err_resp_reg <= (m_axi_bresp != RESP_OKAY) || (m_axi_bid != awid_reg);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        m_axi_awid    = '0;
        m_axi_awaddr  = '0;
        m_axi_awlen   = '0;
        m_axi_awsize  = '0;
        m_axi_awburst = '0;
        m_axi_awcache = '0;
        m_axi_awprot  = '0;
        m_axi_awqos   = '0;
        m_axi_awvalid = 1'b0;
        s_axi_awready = '0;
        m_axi_wdata   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axi_wready  = '0;
        m_axi_bready  = 1'b0;
        s_axi_bvalid  = '0;
        bresp_arr[0]  = '0;
        bresp_arr[1]  = '0;
        unique case (state_reg)
            ST_IDLE: begin
                if (|s_axi_awvalid) state_next = ST_AW;
            end
            ST_AW: begin
                m_axi_awid               = awid_arr[grant_reg];
                m_axi_awaddr             = awaddr_arr[grant_reg];
                m_axi_awlen              = awlen_arr[grant_reg];
                m_axi_awsize             = AWSIZE_32B;
                m_axi_awburst            = AWBURST_INCR;
                m_axi_awcache            = AWCACHE_BUF;
                m_axi_awprot             = AWPROT_DATA;
                m_axi_awqos              = AWQOS_NONE;
                m_axi_awvalid            = s_axi_awvalid[grant_reg];
                s_axi_awready[grant_reg] = m_axi_awready;
                if (aw_hs) state_next = ST_W;
            end
            ST_W: begin
                m_axi_wdata             = wdata_arr[grant_reg];
                m_axi_wvalid            = s_axi_wvalid[grant_reg];
                m_axi_wlast             = last_beat;
                s_axi_wready[grant_reg] = m_axi_wready;
                if (w_hs && last_beat) state_next = ST_B;
            end
            ST_B: begin
                m_axi_bready            = s_axi_bready[grant_reg];
                s_axi_bvalid[grant_reg] = m_axi_bvalid;
                bresp_arr[grant_reg]    = m_axi_bresp;
                if (b_hs) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign m_axi_wstrb = '1;
    assign err_wlast   = err_wlast_reg;
    assign err_resp    = err_resp_reg;

endmodule
